rc_pulse_decoder: RTL

Receive-side counterpart of the motor-controller PWM generator: measures the high time of one incoming servo-style pulse train and converts it back to the same 5-bit power code (0–31) used on the MC command buses. It sits between an external pulse source (RC receiver or a looped-back PWM_MC line for self-test) and the navigation logic. It flags malformed pulses and signal loss so the navigation logic can fail safe.

---
 rtl/rc_pulse_decoder.sv | 136 +++++++++++++
 1 files changed

// File: rtl/rc_pulse_decoder.sv
// Servo-style pulse width decoder: measures the high time of PULSE_IN and maps it to a
// 5-bit power code, with strobes for accepted/rejected pulses and a signal-loss level.
module rc_pulse_decoder #(
  parameter int MIN_VALID = 36400,
  parameter int MIN_WIDTH = 72800,
  parameter int STEP      = 2348,
  parameter int MAX_WIDTH = 182000,
  parameter int TIMEOUT   = 1600000
) (
  input  logic       CLK,
  input  logic       RST,
  input  logic       PULSE_IN,
  output logic [4:0] CODE,
  output logic       VALID,
  output logic       ERR,
  output logic       LOST
);

  localparam int SW = $clog2(STEP + 1);
  localparam logic [20:0]   MIN_V     = 21'(MIN_VALID);
  localparam logic [20:0]   MIN_W     = 21'(MIN_WIDTH);
  localparam logic [20:0]   MAX_W     = 21'(MAX_WIDTH);
  localparam logic [20:0]   TO_W      = 21'(TIMEOUT);
  localparam logic [SW-1:0] STEP_LAST = SW'(STEP - 1);

  typedef enum logic [1:0] {ARM, WAIT_RISE, MEASURE, OVERLONG} state_t;

  state_t        state, state_nxt;
  logic          sync1, s, s_d;
  logic          rise, fall;
  logic [20:0]   cnt;
  logic [SW-1:0] step;
  logic [4:0]    wcode;
  logic [20:0]   timer, timer_nxt;
  logic [1:0]    arm_cnt;
  logic          clr, valid_nxt, err_nxt;

  assign rise = s & ~s_d;
  assign fall = ~s & s_d;

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      sync1 <= 1'b0;
      s     <= 1'b0;
      s_d   <= 1'b0;
    end else begin
      sync1 <= PULSE_IN;
      s     <= sync1;
      s_d   <= s;
    end
  end

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) state <= ARM;
    else     state <= state_nxt;
  end

  // The synchronizer resets low, so ARM waits for it to fill before trusting s.
  always_comb begin
    state_nxt = state;
    valid_nxt = 1'b0;
    err_nxt   = 1'b0;
    clr       = 1'b0;
    case (state)
      ARM:       if (arm_cnt == 2'd3 && !s) state_nxt = WAIT_RISE;
      WAIT_RISE: if (rise) begin
        clr       = 1'b1;
        state_nxt = MEASURE;
      end
      MEASURE: begin
        if (fall) begin
          state_nxt = WAIT_RISE;
          if (cnt < MIN_V || cnt > MAX_W) err_nxt   = 1'b1;
          else                            valid_nxt = 1'b1;
        end else if (cnt > MAX_W) begin
          err_nxt   = 1'b1;
          state_nxt = OVERLONG;
        end
      end
      OVERLONG:  if (fall) state_nxt = WAIT_RISE;
      default:   state_nxt = ARM;
    endcase
  end

  always_ff @(posedge CLK or posedge RST) begin
    if (RST)                              arm_cnt <= 2'd0;
    else if (state == ARM && arm_cnt != 2'd3) arm_cnt <= arm_cnt + 2'd1;
  end

  // Width counter starts at 1 on the rise cycle so cnt equals the high time at fall.
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      cnt   <= '0;
      step  <= '0;
      wcode <= '0;
    end else if (clr) begin
      cnt   <= 21'd1;
      step  <= '0;
      wcode <= '0;
    end else if (state == MEASURE) begin
      if (cnt != '1) cnt <= cnt + 21'd1;
      if (cnt >= MIN_W) begin
        if (step == STEP_LAST) begin
          step <= '0;
          if (wcode != 5'd31) wcode <= wcode + 5'd1;
        end else begin
          step <= step + SW'(1);
        end
      end
    end
  end

  always_comb begin
    timer_nxt = timer;
    if (clr)                timer_nxt = '0;
    else if (timer != TO_W) timer_nxt = timer + 21'd1;
  end

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      timer <= '0;
      LOST  <= 1'b1;
      VALID <= 1'b0;
      ERR   <= 1'b0;
      CODE  <= '0;
    end else begin
      timer <= timer_nxt;
      VALID <= valid_nxt;
      ERR   <= err_nxt;
      if (valid_nxt)               LOST <= 1'b0;
      else if (timer_nxt == TO_W)  LOST <= 1'b1;
      if (valid_nxt) CODE <= wcode;
    end
  end

endmodule
